// File: rtl/xmem_pkg.sv
// Shared definitions for the external SRAM arbiter.
// Holds the controller state encoding, the access-type codes and the helper
// that sizes the wait/grace counter.
package xmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_STB   = 3'd3,
    ST_WR_END   = 3'd4,
    ST_GRACE    = 3'd5
  } xmem_state_t;

  localparam logic ACC_RD = 1'b0;
  localparam logic ACC_WR = 1'b1;

  // Counter must hold the largest of the read wait, write wait and grace.
  function automatic int unsigned xmem_cnt_w(input int unsigned rd_wait,
                                             input int unsigned wr_wait,
                                             input int unsigned grace);
    int unsigned m;
    m = rd_wait;
    if (wr_wait > m) m = wr_wait;
    if (grace > m) m = grace;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/xmem_arb_pick.sv
// Combinational N-wide priority picker.
// Scans the request vector starting at 'start' and wrapping around; the first
// requester found wins.
// Ports: req (request vector), start (first index searched),
//        gnt_c (one-hot grant), idx_c (encoded grant), any_c (some request).
module xmem_arb_pick
  import xmem_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  // Rotating first-one search.
  always_comb begin
    int unsigned p;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    p     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      p = 32'(start) + k;
      if (p >= N) p = p - N;
      if (!any_c && req[IW'(p)]) begin
        any_c          = 1'b1;
        gnt_c[IW'(p)]  = 1'b1;
        idx_c          = IW'(p);
      end
    end
  end

endmodule

// File: rtl/xmem_arbiter_n.sv
// Parametrised external async SRAM controller and arbiter.
// NPORTS requesters share one 16-bit SRAM through a request/ack handshake
// with active-low byte enables. Read/write wait states and the post-write
// grace period are parameters.
// Ports: clock, reset (sync, active-high); per-port port_rd_rq/port_wr_rq,
//        flattened port_addr/port_be_n/port_wdata; shared port_rdata with
//        one-cycle port_rd_ack/port_wr_ack pulses; busy; SRAM pad side
//        SRAM_DAT_out/SRAM_DAT_in/SRAM_DAT_drive, SRAM_ADR, active-low
//        SRAM_CE/SRAM_WE/SRAM_OE/SRAM_BE.
// Build option: define XMEM_RR_ARB_EN for round-robin arbitration; otherwise
// fixed priority with the lowest port index winning.
module xmem_arbiter_n
  import xmem_pkg::*;
#(
  parameter int unsigned NPORTS  = 4,
  parameter int unsigned AW      = 18,
  parameter int unsigned DW      = 16,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 1,
  parameter int unsigned GRACE   = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NPORTS-1:0]          port_rd_rq,
  input  logic [NPORTS-1:0]          port_wr_rq,
  input  logic [NPORTS*AW-1:0]       port_addr,
  input  logic [NPORTS*(DW/8)-1:0]   port_be_n,
  input  logic [NPORTS*DW-1:0]       port_wdata,
  output logic [DW-1:0]              port_rdata,
  output logic [NPORTS-1:0]          port_rd_ack,
  output logic [NPORTS-1:0]          port_wr_ack,
  output logic                       busy,
  output logic [DW-1:0]              SRAM_DAT_out,
  input  logic [DW-1:0]              SRAM_DAT_in,
  output logic                       SRAM_DAT_drive,
  output logic [AW-1:0]              SRAM_ADR,
  output logic                       SRAM_CE,
  output logic                       SRAM_WE,
  output logic                       SRAM_OE,
  output logic [(DW/8)-1:0]          SRAM_BE
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned CW = xmem_cnt_w(RD_WAIT, WR_WAIT, GRACE);

  logic [AW-1:0] addr_a  [NPORTS];
  logic [BW-1:0] be_a    [NPORTS];
  logic [DW-1:0] wdata_a [NPORTS];

  // Unflatten the per-port buses.
  for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
    assign addr_a[i]  = port_addr[i*AW +: AW];
    assign be_a[i]    = port_be_n[i*BW +: BW];
    assign wdata_a[i] = port_wdata[i*DW +: DW];
  end

  xmem_state_t       state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     cur_port;
  logic [NPORTS-1:0] rd_pend, wr_pend;
  logic [NPORTS-1:0] rd_cand_c, wr_cand_c, req_c, gnt_oh_c, rd_clr_c, wr_clr_c;
  logic [IW-1:0]     gnt_idx_c, start_c;
  logic              gnt_any_c, acc_c;

  assign rd_cand_c = port_rd_rq | rd_pend;
  assign wr_cand_c = port_wr_rq | wr_pend;
  assign req_c     = rd_cand_c | wr_cand_c;

  xmem_arb_pick #(.N(NPORTS), .IW(IW)) u_pick (
    .req   (req_c),
    .start (start_c),
    .gnt_c (gnt_oh_c),
    .idx_c (gnt_idx_c),
    .any_c (gnt_any_c)
  );

`ifdef XMEM_RR_ARB_EN
  logic [IW-1:0] last_grant;

  // Search begins one past the most recent winner.
  assign start_c = (last_grant == IW'(NPORTS - 1)) ? '0 : last_grant + IW'(1);

  always_ff @(posedge clock) begin
    if (reset)                            last_grant <= IW'(NPORTS - 1);
    else if (state == ST_IDLE && gnt_any_c) last_grant <= gnt_idx_c;
  end
`else
  assign start_c = '0;
`endif

  // A port's read always goes before its own write.
  assign acc_c = rd_cand_c[gnt_idx_c] ? ACC_RD : ACC_WR;

  // Pending bits to drop on the grant edge.
  always_comb begin
    rd_clr_c = '0;
    wr_clr_c = '0;
    if (state == ST_IDLE && gnt_any_c) begin
      if (acc_c == ACC_RD) rd_clr_c = gnt_oh_c;
      else                 wr_clr_c = gnt_oh_c;
    end
  end

  // Access sequencer with registered strobes, acks and pending latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      cur_port       <= '0;
      rd_pend        <= '0;
      wr_pend        <= '0;
      port_rdata     <= '0;
      port_rd_ack    <= '0;
      port_wr_ack    <= '0;
      busy           <= 1'b0;
      SRAM_DAT_out   <= '0;
      SRAM_DAT_drive <= 1'b0;
      SRAM_ADR       <= '0;
      SRAM_CE        <= 1'b1;
      SRAM_WE        <= 1'b1;
      SRAM_OE        <= 1'b1;
      SRAM_BE        <= '1;
    end else begin
      port_rd_ack <= '0;
      port_wr_ack <= '0;
      rd_pend     <= (rd_pend | port_rd_rq) & ~rd_clr_c;
      wr_pend     <= (wr_pend | port_wr_rq) & ~wr_clr_c;
      case (state)
        ST_IDLE: begin
          if (gnt_any_c) begin
            cur_port <= gnt_idx_c;
            SRAM_ADR <= addr_a[gnt_idx_c];
            SRAM_BE  <= be_a[gnt_idx_c];
            SRAM_CE  <= 1'b0;
            busy     <= 1'b1;
            if (acc_c == ACC_RD) begin
              SRAM_OE <= 1'b0;
              cnt     <= CW'(RD_WAIT);
              state   <= ST_RD;
            end else begin
              SRAM_DAT_out   <= wdata_a[gnt_idx_c];
              SRAM_DAT_drive <= 1'b1;
              state          <= ST_WR_SETUP;
            end
          end
        end
        ST_RD: begin
          if (cnt == CW'(1)) begin
            port_rdata            <= SRAM_DAT_in;
            SRAM_CE               <= 1'b1;
            SRAM_OE               <= 1'b1;
            SRAM_BE               <= '1;
            port_rd_ack[cur_port] <= 1'b1;
            busy                  <= 1'b0;
            state                 <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WR_SETUP: begin
          SRAM_WE <= 1'b0;
          cnt     <= CW'(WR_WAIT);
          state   <= ST_WR_STB;
        end
        ST_WR_STB: begin
          if (cnt == CW'(1)) begin
            SRAM_WE <= 1'b1;
            state   <= ST_WR_END;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WR_END: begin
          // Drive is released one cycle after WE rises for data hold.
          SRAM_CE               <= 1'b1;
          SRAM_DAT_drive        <= 1'b0;
          SRAM_BE               <= '1;
          port_wr_ack[cur_port] <= 1'b1;
          if (GRACE == 0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt   <= CW'(GRACE);
            state <= ST_GRACE;
          end
        end
        ST_GRACE: begin
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xmem_arbiter_n.sv
// Self-checking bench for xmem_arbiter_n: SRAM behavioural model, a
// transaction-level expectation queue built from the arbitration rules, and
// a golden memory updated in ack order.
module tb_xmem_arbiter_n;

  localparam int NP = 4, AW = 18, DW = 16, BW = 2;
  localparam int RD_WAIT = 2, WR_WAIT = 1, GRACE = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP-1:0]     port_rd_rq, port_wr_rq;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*BW-1:0]  port_be_n;
  logic [NP*DW-1:0]  port_wdata;
  logic [DW-1:0]     port_rdata;
  logic [NP-1:0]     port_rd_ack, port_wr_ack;
  logic              busy;
  logic [DW-1:0]     SRAM_DAT_out, SRAM_DAT_in;
  logic              SRAM_DAT_drive;
  logic [AW-1:0]     SRAM_ADR;
  logic              SRAM_CE, SRAM_WE, SRAM_OE;
  logic [BW-1:0]     SRAM_BE;

  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] gold [0:(1<<AW)-1];

  typedef struct {
    int            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be_n;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int we_len = 0, oe_len = 0, drv_len = 0;
  logic [BW-1:0] we_be;
  int mdl_last;

  xmem_arbiter_n #(.NPORTS(NP), .AW(AW), .DW(DW), .RD_WAIT(RD_WAIT),
                   .WR_WAIT(WR_WAIT), .GRACE(GRACE)) dut (
    .clock(clock), .reset(reset),
    .port_rd_rq(port_rd_rq), .port_wr_rq(port_wr_rq),
    .port_addr(port_addr), .port_be_n(port_be_n), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .port_rd_ack(port_rd_ack), .port_wr_ack(port_wr_ack),
    .busy(busy),
    .SRAM_DAT_out(SRAM_DAT_out), .SRAM_DAT_in(SRAM_DAT_in),
    .SRAM_DAT_drive(SRAM_DAT_drive), .SRAM_ADR(SRAM_ADR),
    .SRAM_CE(SRAM_CE), .SRAM_WE(SRAM_WE), .SRAM_OE(SRAM_OE), .SRAM_BE(SRAM_BE)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM read path.
  assign SRAM_DAT_in = (!SRAM_CE && !SRAM_OE) ? mem[SRAM_ADR] : '0;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: SRAM write model, then ack scoreboard and strobe-timing monitor.
  task automatic cyc();
    exp_t e;
    logic [NP-1:0] erd, ewr;
    if (!reset && !SRAM_CE && !SRAM_WE)
      for (int b = 0; b < BW; b++)
        if (!SRAM_BE[b]) mem[SRAM_ADR][8*b +: 8] = SRAM_DAT_out[8*b +: 8];
    @(posedge clock);
    #1;
    if ((port_rd_ack | port_wr_ack) != '0) begin
      if (exp_q.size() == 0) begin
        check("spurious_ack", 64'({port_rd_ack, port_wr_ack}), 64'(0));
      end else begin
        e = exp_q.pop_front();
        erd = '0; ewr = '0;
        if (e.wr) ewr[e.port] = 1'b1; else erd[e.port] = 1'b1;
        check("rd_ack", 64'(port_rd_ack), 64'(erd));
        check("wr_ack", 64'(port_wr_ack), 64'(ewr));
        if (!e.wr) check("rdata", 64'(port_rdata), 64'(gold[e.addr]));
        else
          for (int b = 0; b < BW; b++)
            if (!e.be_n[b]) gold[e.addr][8*b +: 8] = e.wdata[8*b +: 8];
      end
    end
    if (!SRAM_WE) begin
      if (we_len == 0) we_be = SRAM_BE;
      we_len++;
      check("drive_during_we", 64'({SRAM_DAT_drive, SRAM_CE}), 64'(2'b10));
    end else if (we_len != 0) begin
      if (!reset) begin
        check("we_len", 64'(we_len), 64'(WR_WAIT));
        check("drive_hold", 64'(SRAM_DAT_drive), 64'(1));
      end
      we_len = 0;
    end
    if (!SRAM_OE) oe_len++;
    else if (oe_len != 0) begin
      if (!reset) check("oe_len", 64'(oe_len), 64'(RD_WAIT));
      oe_len = 0;
    end
    if (SRAM_DAT_drive) drv_len++;
    else if (drv_len != 0) begin
      if (!reset) check("drive_len", 64'(drv_len), 64'(WR_WAIT + 2));
      drv_len = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [BW-1:0] be,
                          input logic [DW-1:0] d);
    port_addr[p*AW +: AW]  = a;
    port_be_n[p*BW +: BW]  = be;
    port_wdata[p*DW +: DW] = d;
  endtask

  task automatic push_exp(input int p, input bit wr);
    exp_t e;
    e.port  = p;
    e.wr    = wr;
    e.addr  = port_addr[p*AW +: AW];
    e.be_n  = port_be_n[p*BW +: BW];
    e.wdata = port_wdata[p*DW +: DW];
    exp_q.push_back(e);
  endtask

  // Service order for requests that all arrive together: one op per grant,
  // read before write on a port, scan from port 0 (fixed) or last+1 (RR).
  task automatic model_order(input logic [NP-1:0] rd, input logic [NP-1:0] wr);
    logic [NP-1:0] r, w;
    int start, p;
    r = rd; w = wr;
    while ((r | w) != '0) begin
`ifdef XMEM_RR_ARB_EN
      start = (mdl_last + 1) % NP;
`else
      start = 0;
`endif
      for (int k = 0; k < NP; k++) begin
        p = (start + k) % NP;
        if (r[p] || w[p]) begin
          push_exp(p, !r[p]);
          if (r[p]) r[p] = 1'b0; else w[p] = 1'b0;
          mdl_last = p;
          break;
        end
      end
    end
  endtask

  task automatic drain(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cyc();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic run_batch(input logic [NP-1:0] rd, input logic [NP-1:0] wr, output int n);
    int m;
    model_order(rd, wr);
    port_rd_rq = rd;
    port_wr_rq = wr;
    cyc();
    port_rd_rq = '0;
    port_wr_rq = '0;
    drain(m);
    n = m + 1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    port_rd_rq = '0; port_wr_rq = '0;
    port_addr = '0; port_be_n = '1; port_wdata = '0;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]  = DW'(a) ^ 16'h5A5A;
      gold[a] = mem[a];
    end
    mem[18'h2A55] = 16'hBEEF;  gold[18'h2A55] = 16'hBEEF;
    mem[18'h20001] = 16'hA5C3; gold[18'h20001] = 16'hA5C3;
    mdl_last = NP - 1;

    // Reset values
    idle(3);
    check("rst_strobes", 64'({SRAM_CE, SRAM_WE, SRAM_OE, SRAM_DAT_drive, busy}), 64'(5'b11100));
    check("rst_be", 64'(SRAM_BE), 64'(2'b11));
    check("rst_acks", 64'({port_rd_ack, port_wr_ack}), 64'(0));
    check("rst_data", 64'({SRAM_ADR, SRAM_DAT_out, port_rdata}), 64'(0));
    reset = 1'b0;
    idle(2);

    // Single read on port 1
    set_port(1, 18'h02A55, 2'b00, 16'h0);
    run_batch(4'b0010, 4'b0000, n);
    check("rd_latency", 64'(n), 64'(RD_WAIT + 1));
    check("rd_data", 64'(port_rdata), 64'(16'hBEEF));
    check("rd_be_restored", 64'(SRAM_BE), 64'(2'b11));
    idle(2);

    // Byte write on port 0, low lane only
    set_port(0, 18'h20001, 2'b10, 16'h1234);
    run_batch(4'b0000, 4'b0001, n);
    check("wr_latency", 64'(n), 64'(WR_WAIT + 3));
    check("wr_be", 64'(we_be), 64'(2'b10));
    check("grace_busy", 64'(busy), 64'(1));
    cyc();
    check("grace_done", 64'(busy), 64'(0));
    check("wr_lane", 64'(mem[18'h20001]), 64'(16'hA534));
    idle(2);

    // Contention: prime last winner = 2, then ports 0, 2, 3 read together
    set_port(2, 18'h00102, 2'b00, 16'h0);
    run_batch(4'b0100, 4'b0000, n);
    idle(2);
    set_port(0, 18'h00100, 2'b00, 16'h0);
    set_port(3, 18'h00103, 2'b00, 16'h0);
    run_batch(4'b1101, 4'b0000, n);
    idle(2);

    // Pending merge: port 3 write pulsed three cycles while busy
    set_port(0, 18'h00200, 2'b00, 16'hCAFE);
    set_port(3, 18'h00201, 2'b01, 16'h7788);
    push_exp(0, 1'b1);
    push_exp(3, 1'b1);
    mdl_last = 3;
    port_wr_rq[0] = 1'b1;
    cyc();
    port_wr_rq[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      port_wr_rq[3] = 1'b1;
      cyc();
    end
    port_wr_rq[3] = 1'b0;
    drain(n);
    idle(8);
    check("merge_idle", 64'(busy), 64'(0));

    // Same-port read+write, plus a port 2 read arriving on the read-ack edge
    set_port(1, 18'h00105, 2'b00, 16'h1357);
    set_port(2, 18'h00106, 2'b11, 16'h0);
    push_exp(1, 1'b0);
`ifdef XMEM_RR_ARB_EN
    push_exp(2, 1'b0);
    push_exp(1, 1'b1);
    mdl_last = 1;
`else
    push_exp(1, 1'b1);
    push_exp(2, 1'b0);
    mdl_last = 2;
`endif
    port_rd_rq[1] = 1'b1;
    port_wr_rq[1] = 1'b1;
    cyc();
    port_rd_rq = '0;
    port_wr_rq = '0;
    cyc();
    port_rd_rq[2] = 1'b1;
    cyc();
    port_rd_rq[2] = 1'b0;
    check("ack_edge_rd1", 64'(port_rd_ack), 64'(4'b0010));
    drain(n);
    idle(4);

    // Randomized batches
    for (int b = 0; b < 40; b++) begin
      for (int p = 0; p < NP; p++)
        set_port(p, AW'(18'h00100 + $urandom_range(0, 15)), BW'($urandom_range(0, 3)),
                 DW'($urandom));
      run_batch(NP'($urandom_range(0, 15)), NP'($urandom_range(0, 15)), n);
      idle(int'($urandom_range(0, 3)));
    end
    idle(6);

    // Reset during the write strobe, with a read pending on port 2
    set_port(0, 18'h3FFFF, 2'b00, 16'hDEAD);
    port_wr_rq[0] = 1'b1;
    cyc();
    port_wr_rq[0] = 1'b0;
    port_rd_rq[2] = 1'b1;
    cyc();
    port_rd_rq[2] = 1'b0;
    check("pre_rst_we", 64'({SRAM_WE, busy}), 64'(2'b01));
    reset = 1'b1;
    cyc();
    check("rst_abort_strobes", 64'({SRAM_CE, SRAM_WE, SRAM_OE, SRAM_DAT_drive, busy}),
          64'(5'b11100));
    check("rst_abort_acks", 64'({port_rd_ack, port_wr_ack}), 64'(0));
    reset = 1'b0;
    mdl_last = NP - 1;
    idle(10);
    check("rst_pend_cleared", 64'({busy, SRAM_OE}), 64'(2'b01));

    // Final memory image
    for (int a = 'h100; a < 'h110; a++)
      check("mem_img", 64'(mem[a]), 64'(gold[a]));
    check("mem_200", 64'(mem[18'h00200]), 64'(16'hCAFE));
    check("mem_201", 64'(mem[18'h00201]), 64'(gold[18'h00201]));
    check("mem_20001", 64'(mem[18'h20001]), 64'(16'hA534));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xmem_arbiter_n.md
Name: xmem_arbiter_n

Overview:
- Parametrised external SRAM controller and arbiter for the EP994A/icy99 design.
- Connects NPORTS generic requesters (CPU, VDP, flash loader, serloader, future DMA/sound) to one asynchronous 16-bit SRAM.
- Each port has a uniform request/ack handshake with byte enables.
- Read and write wait states are set by parameters instead of fixed state chains.

Parameters:
NPORTS, 4, number of requester ports (1..8)
AW, 18, SRAM word-address width
DW, 16, data width (multiple of 8); BW = DW/8 byte lanes
RD_WAIT, 2, cycles OE held low before data capture (>=1)
WR_WAIT, 1, cycles WE held low (>=1)
GRACE, 1, idle cycles after each write (0..3)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
port_rd_rq  in  NPORTS  per-port read request pulse/level
port_wr_rq  in  NPORTS  per-port write request pulse/level
port_addr  in  NPORTS*AW  flattened word addresses, port i at [i*AW +: AW]
port_be_n  in  NPORTS*BW  flattened active-low byte enables
port_wdata  in  NPORTS*DW  flattened write data
port_rdata  out  DW  read data, shared by all ports, valid with the read ack
port_rd_ack  out  NPORTS  one-cycle read-done pulse
port_wr_ack  out  NPORTS  one-cycle write-done pulse
busy  out  1  high whenever not IDLE
SRAM_DAT_out  out  DW  write data to pads
SRAM_DAT_in  in  DW  read data from pads
SRAM_DAT_drive  out  1  pad output enable
SRAM_ADR  out  AW  word address
SRAM_CE, SRAM_WE, SRAM_OE  out  1 each  active-low strobes
SRAM_BE  out  BW  active-low byte enables

Behaviour:
- Reset values:
  - SRAM_CE/WE/OE = 1; SRAM_DAT_drive = 0; SRAM_BE = all 1.
  - All acks = 0; busy = 0; all pending bits cleared; state IDLE.
  - SRAM_ADR, SRAM_DAT_out and port_rdata are 0.
- Reset mid-cycle: strobes are released on the next edge and no ack is issued for the aborted access.
- Pending latches:
  - A request sets rd_pend[i] or wr_pend[i] each cycle it is high.
  - A pending bit clears on the edge that grants it.
  - Only one outstanding read and one outstanding write per port; further requests before grant merge into it.
- Arbitration in IDLE:
  - Candidates are (rq | pend) per port.
  - Reads beat writes within a port.
  - Fixed priority, lowest index wins (port 0 = VDP by convention).
  - Address, BE and data are sampled from the granted port on the grant edge.
- States: IDLE, RD, WR_SETUP, WR_STB, WR_END, GRACE.
- Read:
  - Grant edge: CE = 0, OE = 0, ADR and BE loaded, cnt = RD_WAIT; go to RD.
  - RD decrements cnt. When cnt == 1: capture port_rdata <= SRAM_DAT_in, CE/OE = 1, pulse port_rd_ack[i], go to IDLE.
  - Latency from the request-sample edge to ack = RD_WAIT+1 cycles.
  - No grace after a read. Back-to-back reads are allowed: IDLE arbitrates the next read one cycle after the ack.
- Write:
  - Grant edge: CE = 0, drive = 1, DAT_out/ADR/BE loaded; go to WR_SETUP.
  - WR_SETUP: WE = 0, cnt = WR_WAIT; go to WR_STB.
  - WR_STB decrements cnt. At cnt == 1: WE = 1; go to WR_END.
  - WR_END: CE = 1, drive = 0, pulse port_wr_ack[i]; go to GRACE, or IDLE if GRACE == 0.
  - GRACE counts GRACE cycles with all strobes high.
- Address, data and BE are stable throughout WE low. Drive stays high one cycle past WE rising (hold time).
- Simultaneous events:
  - A request arriving on the same edge as its port's ack sets the pending bit and is served next.
  - Rd and wr requests on the same port in the same cycle: the read is served first, then the write.
- BE of all ones is legal: a dummy cycle that is still acked.
- Counters are $clog2(max(RD_WAIT,WR_WAIT,GRACE)+1) bits wide.

Optional Feature:
- XMEM_RR_ARB_EN defined:
  - Round-robin arbitration; the search starts at (last_grant+1) mod NPORTS.
  - last_grant resets to NPORTS-1.
- XMEM_RR_ARB_EN undefined:
  - Fixed lowest-index priority as above; no last_grant register.

Decomposition:
- Package xmem_pkg holds:
  - the state encoding constants (IDLE=0, RD=1, WR_SETUP=2, WR_STB=3, WR_END=4, GRACE=5);
  - the access-type constants (ACC_RD, ACC_WR).
- Sub-module xmem_arb_pick: combinational NPORTS-wide picker.
  - Inputs: request vector and start index.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once; the start index is tied to 0 when round-robin is off.

Test Plan:
- Single read, RD_WAIT=2: port 1 rd_rq pulse, addr=0x2A55, SRAM model returns 0xBEEF -> OE low exactly 2 cycles, port_rd_ack[1] 3 cycles after request, port_rdata=0xBEEF, BE=2'b11 restored.
- Byte write: port 0 wr_rq, addr=0x20001, be_n=2'b10, wdata=0x1234 -> SRAM_BE=2'b10, WE low WR_WAIT cycles, drive covers WE low plus 1, one wr_ack, GRACE idle cycle, model lane[7:0]=0x34 only.
- Contention: ports 0, 2 and 3 read in the same cycle -> fixed mode grants order 0,2,3. With XMEM_RR_ARB_EN and last_grant=2, order is 3,0,2. Each port gets exactly one ack.
- Pending merge: port 3 pulses wr_rq on 3 consecutive cycles while busy -> exactly one write, one ack.
- Same-port rd+wr together on port 1 -> read ack precedes write ack. A request on the ack edge is served afterwards.
- Reset asserted during WR_STB -> next edge WE/CE=1, drive=0, no ack, pending cleared, busy=0.
